// File: rtl/pattern_sweep_controller_if.sv
// rtl/pattern_sweep_controller_if.sv - sweep control, DUT stimulus/response and log stream bundle
interface pattern_sweep_controller_if #(
    parameter int WIDTH = 5
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] vec_out;
    logic             dut_resp;
    logic             log_valid;
    logic             log_ready;
    logic [WIDTH-1:0] log_vec;
    logic             log_resp;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   ones_count;
    logic [15:0]      signature;

    modport master (
        input  start, abort, dut_resp, log_ready,
        output vec_out, log_valid, log_vec, log_resp, busy, done, ones_count, signature
    );

    modport slave (
        output start, abort, dut_resp, log_ready,
        input  vec_out, log_valid, log_vec, log_resp, busy, done, ones_count, signature
    );
endinterface

// File: rtl/pattern_sweep_controller.sv
// rtl/pattern_sweep_controller.sv - exhaustive vector sweep with settle, sample and logged responses
// Optional response signature LFSR enabled by PATTERN_SWEEP_SIGNATURE_EN.
module pattern_sweep_controller #(
    parameter int WIDTH      = 5,
    parameter int SETTLE_CYC = 1
) (
    input  logic                      CK,
    input  logic                      reset,
    pattern_sweep_controller_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_LOG    = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [WIDTH-1:0] VEC_LAST    = '1;
    localparam logic [WIDTH-1:0] VEC_ONE     = 1;
    localparam logic [WIDTH:0]   ONES_MAX    = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH:0]   ONES_ONE    = 1;
    localparam logic [7:0]       SETTLE_LAST = (SETTLE_CYC > 0) ? 8'(SETTLE_CYC - 1) : 8'd0;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_vec;
    logic [WIDTH-1:0] r_log_vec;
    logic             r_log_resp;
    logic [WIDTH:0]   r_ones;
    logic [7:0]       r_settle_cnt;
    logic             w_abort;
    logic             w_busy;
    logic             w_done;
    logic             w_log_valid;

    // Abort only has meaning once a sweep is running; in IDLE start always wins.
    assign w_abort = bus.abort && (r_state != S_IDLE);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (bus.start) w_next = S_APPLY;
                S_APPLY:  w_next = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
                S_SETTLE: if (r_settle_cnt == SETTLE_LAST) w_next = S_SAMPLE;
                S_SAMPLE: w_next = S_LOG;
                S_LOG:    if (bus.log_ready) w_next = (r_vec == VEC_LAST) ? S_DONE : S_APPLY;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_done      = (r_state == S_DONE);
        w_log_valid = (r_state == S_LOG);
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_vec        <= '0;
            r_log_vec    <= '0;
            r_log_resp   <= 1'b0;
            r_ones       <= '0;
            r_settle_cnt <= 8'd0;
        end else if (w_abort) begin
            r_vec        <= '0;
            r_settle_cnt <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_vec  <= '0;
                        r_ones <= '0;
                    end
                end
                S_APPLY:  r_settle_cnt <= 8'd0;
                S_SETTLE: r_settle_cnt <= r_settle_cnt + 8'd1;
                S_SAMPLE: begin
                    r_log_vec  <= r_vec;
                    r_log_resp <= bus.dut_resp;
                    if (bus.dut_resp && (r_ones != ONES_MAX)) begin
                        r_ones <= r_ones + ONES_ONE;
                    end
                end
                S_LOG: begin
                    // The last vector is held so vec_out never wraps inside a sweep.
                    if (bus.log_ready && (r_vec != VEC_LAST)) begin
                        r_vec <= r_vec + VEC_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PATTERN_SWEEP_SIGNATURE_EN
    logic [15:0] r_sig;

    // CRC-CCITT style shift: feedback is the response XOR the outgoing MSB.
    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            r_sig <= 16'h0000;
        end else if ((r_state == S_IDLE) && bus.start) begin
            r_sig <= 16'hFFFF;
        end else if ((r_state == S_SAMPLE) && !w_abort) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ ((bus.dut_resp ^ r_sig[15]) ? 16'h1021 : 16'h0000);
        end
    end

    assign bus.signature = r_sig;
`else
    assign bus.signature = 16'h0000;
`endif

    assign bus.vec_out    = r_vec;
    assign bus.log_vec    = r_log_vec;
    assign bus.log_resp   = r_log_resp;
    assign bus.log_valid  = w_log_valid;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.ones_count = r_ones;
endmodule

// File: tb/tb_pattern_sweep_controller.sv
// tb/tb_pattern_sweep_controller.sv - directed and randomized sweeps against a response-table model
module tb_pattern_sweep_controller;
    localparam int W     = 5;
    localparam int NVEC  = 32;

    logic CK    = 1'b0;
    logic reset = 1'b0;
    int   tests = 0;
    int   fails = 0;
    bit   resp_tab [NVEC];

    always #5 CK = ~CK;

    pattern_sweep_controller_if #(.WIDTH(W)) if0 ();
    pattern_sweep_controller_if #(.WIDTH(W)) if1 ();

    assign if0.dut_resp = resp_tab[if0.vec_out];
    assign if1.dut_resp = if1.vec_out[1];

    pattern_sweep_controller #(.WIDTH(W), .SETTLE_CYC(1)) u_dut (
        .CK    (CK),
        .reset (reset),
        .bus   (if0)
    );

    pattern_sweep_controller #(.WIDTH(W), .SETTLE_CYC(0)) u_dut0 (
        .CK    (CK),
        .reset (reset),
        .bus   (if1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    function automatic logic [15:0] sig_init();
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        return 16'hFFFF;
`else
        return 16'h0000;
`endif
    endfunction

    // Bit-serial division by x^16+x^12+x^5+1 over the responses in vector order.
    function automatic logic [15:0] ref_sig();
        logic [15:0] s;
        logic        fb;
        s = sig_init();
`ifdef PATTERN_SWEEP_SIGNATURE_EN
        for (int v = 0; v < NVEC; v++) begin
            fb = resp_tab[v] ^ s[15];
            s  = s << 1;
            if (fb) s = s ^ 16'h1021;
        end
`endif
        return s;
    endfunction

    function automatic int ref_ones();
        int n = 0;
        for (int v = 0; v < NVEC; v++) n += int'(resp_tab[v]);
        return n;
    endfunction

    task automatic fill_random();
        for (int v = 0; v < NVEC; v++) resp_tab[v] = 1'($urandom_range(0, 1));
    endtask

    task automatic run_sweep(input string name, input int stall_vec, input int stall_len, input int exp_cycles);
        int         idx;
        int         cyc;
        int         stalled;
        logic [4:0] held_vec;
        logic       held_resp;
        if0.log_ready = 1'b1;
        if0.start     = 1'b1;
        step();
        if0.start = 1'b0;
        check({name, "_start_vec"}, 32'(if0.vec_out), 32'd0);
        check({name, "_start_busy"}, 32'(if0.busy), 32'd1);
        check({name, "_start_ones"}, 32'(if0.ones_count), 32'd0);
        check({name, "_start_sig"}, 32'(if0.signature), 32'(sig_init()));
        idx = 0; cyc = 0; stalled = 0;
        held_vec = '0; held_resp = 1'b0;
        while (!if0.done && cyc < 1000) begin
            if0.log_ready = 1'b1;
            if (if0.log_valid) begin
                if (idx == stall_vec && stalled < stall_len) begin
                    if (stalled == 0) begin
                        held_vec  = if0.log_vec;
                        held_resp = if0.log_resp;
                    end else begin
                        check({name, "_stall_vec"}, 32'(if0.log_vec), 32'(held_vec));
                        check({name, "_stall_resp"}, 32'(if0.log_resp), 32'(held_resp));
                    end
                    if0.log_ready = 1'b0;
                    stalled++;
                end else begin
                    check({name, "_rec_vec"}, 32'(if0.log_vec), 32'(idx));
                    check({name, "_rec_resp"}, 32'(if0.log_resp), 32'(resp_tab[idx[4:0]]));
                    idx++;
                end
            end
            step();
            cyc++;
        end
        if0.log_ready = 1'b1;
        check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({name, "_records"}, 32'(idx), 32'(NVEC));
        check({name, "_done"}, 32'(if0.done), 32'd1);
        check({name, "_ones"}, 32'(if0.ones_count), 32'(ref_ones()));
        check({name, "_sig"}, 32'(if0.signature), 32'(ref_sig()));
        step();
        check({name, "_done_pulse"}, 32'(if0.done), 32'd0);
        check({name, "_idle_busy"}, 32'(if0.busy), 32'd0);
        check({name, "_hold_ones"}, 32'(if0.ones_count), 32'(ref_ones()));
        check({name, "_hold_sig"}, 32'(if0.signature), 32'(ref_sig()));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_vec"}, 32'(if0.vec_out), 32'd0);
        check({name, "_lvalid"}, 32'(if0.log_valid), 32'd0);
        check({name, "_lvec"}, 32'(if0.log_vec), 32'd0);
        check({name, "_lresp"}, 32'(if0.log_resp), 32'd0);
        check({name, "_busy"}, 32'(if0.busy), 32'd0);
        check({name, "_done"}, 32'(if0.done), 32'd0);
        check({name, "_ones"}, 32'(if0.ones_count), 32'd0);
        check({name, "_sig"}, 32'(if0.signature), 32'd0);
    endtask

    initial begin
        int cnt;
        int recs;
        if0.start = 1'b0; if0.abort = 1'b0; if0.log_ready = 1'b1;
        if1.start = 1'b0; if1.abort = 1'b0; if1.log_ready = 1'b1;
        for (int v = 0; v < NVEC; v++) resp_tab[v] = 1'b0;

        #12;
        check_reset_outputs("por");
        step();
        reset = 1'b1;
        step();
        check("idle_busy", 32'(if0.busy), 32'd0);

        run_sweep("zeros", -1, 0, 128);

        for (int v = 0; v < NVEC; v++) resp_tab[v] = v[0];
        run_sweep("lsb", -1, 0, 128);

        fill_random();
        run_sweep("stall7", 7, 5, 133);

        for (int r = 0; r < 3; r++) begin
            int sv;
            int sl;
            sv = int'($urandom_range(0, 31));
            sl = int'($urandom_range(0, 6));
            fill_random();
            run_sweep("rand", sv, sl, 128 + sl);
        end

        // Abort while settling vector 12.
        fill_random();
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        repeat (4 * 12 + 1) step();
        check("abort_pre_vec", 32'(if0.vec_out), 32'd12);
        if0.abort = 1'b1;
        step();
        if0.abort = 1'b0;
        check("abort_busy", 32'(if0.busy), 32'd0);
        check("abort_vec", 32'(if0.vec_out), 32'd0);
        check("abort_done", 32'(if0.done), 32'd0);
        check("abort_lvalid", 32'(if0.log_valid), 32'd0);
        step();
        check("abort_stay_idle", 32'(if0.busy), 32'd0);
        run_sweep("after_abort", -1, 0, 128);

        // Abort beats a simultaneous LOG handshake at vector 3.
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        repeat (4 * 3 + 3) step();
        check("abl_lvalid", 32'(if0.log_valid), 32'd1);
        check("abl_lvec", 32'(if0.log_vec), 32'd3);
        if0.abort = 1'b1;
        if0.log_ready = 1'b1;
        step();
        if0.abort = 1'b0;
        check("abl_busy", 32'(if0.busy), 32'd0);
        check("abl_vec", 32'(if0.vec_out), 32'd0);
        check("abl_done", 32'(if0.done), 32'd0);

        // Start and abort together in IDLE: start wins.
        if0.start = 1'b1;
        if0.abort = 1'b1;
        step();
        if0.start = 1'b0;
        check("start_wins_busy", 32'(if0.busy), 32'd1);
        step();
        if0.abort = 1'b0;
        check("start_wins_abort", 32'(if0.busy), 32'd0);

        // Asynchronous reset in LOG at vector 20.
        fill_random();
        if0.start = 1'b1;
        step();
        if0.start = 1'b0;
        repeat (4 * 20 + 3) step();
        check("rst_pre_lvalid", 32'(if0.log_valid), 32'd1);
        check("rst_pre_lvec", 32'(if0.log_vec), 32'd20);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step();
        reset = 1'b1;
        step();
        check("post_rst_busy", 32'(if0.busy), 32'd0);
        check("post_rst_done", 32'(if0.done), 32'd0);
        run_sweep("after_rst", -1, 0, 128);

        // Zero-settle instance with start held high for the whole sweep.
        if1.log_ready = 1'b1;
        if1.start = 1'b1;
        step();
        cnt = 0; recs = 0;
        while (!if1.done && cnt < 1000) begin
            if (if1.log_valid) recs++;
            step();
            cnt++;
        end
        if1.start = 1'b0;
        check("s0_cycles", 32'(cnt), 32'd96);
        check("s0_records", 32'(recs), 32'd32);
        check("s0_ones", 32'(if1.ones_count), 32'd16);
        step();
        check("s0_idle", 32'(if1.busy), 32'd0);
        check("s0_vec", 32'(if1.vec_out), 32'd31);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
